t07_writeback_unit: RTL
=======================

T07_WRITEBACK_UNIT -- requirements
Module: t07_writeback_unit

Interface
REQ-001 SHALL have the following ports:
- clk  in  1  system clock; all state updates on posedge.
- nrst  in  1  reset, asynchronous, active-low.
- valid_i  in  1  one-cycle pulse issuing a writeback request.
- wb_sel_i  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 none.
- rd_i  in  5  destination register index.
- funct3_i  in  3  load width/sign code.
- alu_result_i  in  32  ALU result; for loads, the byte address.
- pc_plus4_i  in  32  link value.
- freeze_i  in  1  pipeline freeze.
- mem_ack_i  in  1  memory read-data-valid acknowledge.
- mem_rdata_i  in  32  memory read word.
- mem_req_o  out  1  memory read request.
- mem_addr_o  out  32  word-aligned read address.
- write_reg_o  out  5  register-file write index.
- write_data_o  out  32  register-file write data.
- reg_write_o  out  1  register-file write strobe.
- busy_o  out  1  request in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle misaligned or illegal-load pulse.

Function
REQ-002 SHALL implement a 3-state FSM: IDLE, MEM_WAIT, WRITE.
REQ-003 In IDLE with valid_i=1 and freeze_i=0, the unit SHALL latch rd_i, funct3_i, alu_result_i, pc_plus4_i and wb_sel_i.
REQ-004 In that case, wb_sel 00/10 SHALL go to WRITE, wb_sel 01 SHALL go to MEM_WAIT, and wb_sel 11 SHALL stay in IDLE and pulse done_o the next cycle.
REQ-005 valid_i outside IDLE SHALL be ignored; busy_o SHALL equal (state != IDLE).
REQ-006 In MEM_WAIT, mem_req_o SHALL be 1 and mem_addr_o SHALL be {addr[31:2],2'b00}, both held stable until mem_ack_i=1 is sampled.
REQ-007 On the mem_ack_i cycle, the unit SHALL capture mem_rdata_i and go to WRITE; mem_req_o SHALL drop the following cycle.
REQ-008 Load extraction SHALL use byte offset addr[1:0] and funct3:
- 000 LB: sign-extended byte.
- 001 LH: sign-extended halfword.
- 010 LW: full word.
- 100 LBU: zero-extended byte.
- 101 LHU: zero-extended halfword.
- Little-endian byte order.
REQ-009 The following SHALL suppress the write and pulse err_o with done_o: LH/LHU with addr[0]=1, LW with addr[1:0]!=0, or funct3 of 011/110/111.
- The misalignment or illegal code SHALL be detected in IDLE at acceptance.
- No memory request SHALL be issued.
- The FSM SHALL return to IDLE.
REQ-010 In WRITE, the unit SHALL drive the following, then return to IDLE:
- reg_write_o=1 for exactly one cycle.
- write_reg_o=latched rd.
- write_data_o = ALU result, PC+4 or extended load data per wb_sel.
- done_o=1.
REQ-011 When latched rd=0, reg_write_o SHALL stay 0 while done_o still pulses.
REQ-012 Latency, valid_i cycle = cycle 0:
- ALU/PC+4: reg_write_o in cycle 1.
- Load: mem_req_o from cycle 1; reg_write_o one cycle after the ack cycle.
- Minimum load latency: 2 cycles.
REQ-013 While freeze_i=1:
- FSM and all latched data SHALL hold.
- reg_write_o, done_o and err_o SHALL be forced 0.
- mem_req_o SHALL keep its value.
- A mem_ack_i arriving during freeze SHALL still capture data, with the WRITE transition deferred until freeze_i=0.
REQ-014 write_reg_o and write_data_o SHALL hold their last values when reg_write_o=0.

Reset
REQ-015 With nrst=0, the FSM SHALL go to IDLE immediately, and all outputs and latched fields SHALL be 0.
REQ-016 Reset mid-load SHALL abandon the request with no write; a mem_ack_i arriving after reset release while in IDLE SHALL be ignored.

Structure
REQ-017 The shared package t07_pkg SHALL hold:
- the wb_sel enum (WB_ALU, WB_LOAD, WB_PC4, WB_NONE);
- the FSM state enum;
- the funct3 load constants.
REQ-018 Byte/halfword selection and extension SHALL live in combinational sub-module t07_load_extend (inputs: word, offset, funct3; outputs: data, illegal).

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ALU writeback: wb_sel=00, rd=5, alu=0xDEADBEEF -> cycle 1: reg_write_o=1, write_reg_o=5, write_data_o=0xDEADBEEF, done_o=1.
- LB sign extension: addr=0x1003, funct3=000, ack after 3 cycles with rdata=0x80FF1234 -> mem_addr_o=0x1000 held 3 cycles; write_data_o=0xFFFFFF80.
- LHU upper half: addr=0x2002, funct3=101, rdata=0xBEEF0000 -> write_data_o=0x0000BEEF.
- Misaligned LW: addr=0x0001, funct3=010 -> err_o=1, done_o=1, no mem_req_o, no reg_write_o.
- rd=0 and JAL link: rd=0, wb_sel=10 -> done_o=1, reg_write_o=0; rd=1, pc_plus4=0x104 -> write_data_o=0x104.
- Freeze and reset mid-load: freeze_i=1 across ack -> write deferred until freeze_i=0; nrst=0 in MEM_WAIT -> mem_req_o=0, busy_o=0, no write.

Source files
------------

// File: rtl/t07_pkg.sv
// t07_pkg: shared types and constants for the writeback unit.
// Holds the result-source select, FSM state and load funct3 codes.
package t07_pkg;

    // Result source for a writeback request
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_e;

    // Writeback FSM states
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_WRITE    = 2'd2
    } state_e;

    // Load width/sign codes (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/t07_load_extend.sv
// t07_load_extend: combinational little-endian byte/halfword selection
// and sign/zero extension of a memory read word.
// Ports: word/offset/funct3 in; data (extended value), illegal (misaligned
// access or unsupported funct3) out.
module t07_load_extend
    import t07_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        illegal
);

    logic [15:0] half;
    logic [7:0]  byte_v;

    // Bytes from the addressed offset upward; the top-byte case only
    // feeds byte loads, since a halfword there is misaligned anyway.
    always_comb begin
        half = 16'h0000;
        unique case (offset)
            2'd0:    half = word[15:0];
            2'd1:    half = word[23:8];
            2'd2:    half = word[31:16];
            default: half = {8'h00, word[31:24]};
        endcase
        byte_v = half[7:0];
    end

    always_comb begin
        data    = 32'h0000_0000;
        illegal = 1'b0;
        unique case (funct3)
            F3_LB: begin
                data = {{24{byte_v[7]}}, byte_v};
            end
            F3_LH: begin
                data    = {{16{half[15]}}, half};
                illegal = offset[0];
            end
            F3_LW: begin
                data    = word;
                illegal = |offset;
            end
            F3_LBU: begin
                data = {24'h00_0000, byte_v};
            end
            F3_LHU: begin
                data    = {16'h0000, half};
                illegal = offset[0];
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/t07_writeback_unit.sv
// t07_writeback_unit: accepts a writeback request, optionally fetches a
// load word from memory, extends it and writes the register file once.
// Ports: clk/nrst; request (valid_i, wb_sel_i, rd_i, funct3_i,
// alu_result_i, pc_plus4_i); freeze_i; memory read port (mem_req_o,
// mem_addr_o, mem_ack_i, mem_rdata_i); register write port (write_reg_o,
// write_data_o, reg_write_o); status (busy_o, done_o, err_o).
module t07_writeback_unit
    import t07_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        valid_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [4:0]  rd_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] pc_plus4_i,
    input  logic        freeze_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [4:0]  write_reg_o,
    output logic [31:0] write_data_o,
    output logic        reg_write_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    state_e      state;
    state_e      state_nxt;
    wb_sel_e     sel_in;
    wb_sel_e     sel_q;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] pc4_q;
    logic [31:0] rdata_q;
    logic        ack_q;
    logic        done_pend_q;
    logic        err_pend_q;
    logic [4:0]  wreg_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        capture;
    logic        ld_illegal;
    logic        ld_reject;
    logic [31:0] ld_data;
    logic [31:0] wb_value;
    logic [1:0]  le_off;
    logic [2:0]  le_f3;

    assign sel_in    = wb_sel_e'(wb_sel_i);
    assign accept    = (state == S_IDLE) && valid_i && !freeze_i;
    assign ld_reject = (sel_in == WB_LOAD) && ld_illegal;

    // First ack only; the word stays captured even if frozen.
    assign capture = (state == S_MEM_WAIT) && mem_ack_i && !ack_q;

    // In IDLE the extender checks the incoming request for legality;
    // afterwards it extends the captured word with the latched fields.
    assign le_off = (state == S_IDLE) ? alu_result_i[1:0] : addr_q[1:0];
    assign le_f3  = (state == S_IDLE) ? funct3_i : f3_q;

    t07_load_extend u_ext (
        .word    (rdata_q),
        .offset  (le_off),
        .funct3  (le_f3),
        .data    (ld_data),
        .illegal (ld_illegal)
    );

    always_comb begin
        wb_value = addr_q;
        unique case (1'b1)
            sel_q == WB_LOAD: wb_value = ld_data;
            sel_q == WB_PC4:  wb_value = pc4_q;
            default:          wb_value = addr_q;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        reg_write_o = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        mem_req_o   = (state == S_MEM_WAIT);
        busy_o      = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (done_pend_q && !freeze_i) begin
                    done_o = 1'b1;
                    err_o  = err_pend_q;
                end
                if (accept) begin
                    unique case (sel_in)
                        WB_ALU:  state_nxt = S_WRITE;
                        WB_PC4:  state_nxt = S_WRITE;
                        WB_LOAD: state_nxt = ld_illegal ? S_IDLE
                                                        : S_MEM_WAIT;
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_MEM_WAIT: begin
                if (!freeze_i && (mem_ack_i || ack_q)) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!freeze_i) begin
                    done_o      = 1'b1;
                    reg_write_o = |rd_q;
                    state_nxt   = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sel_q       <= WB_ALU;
            rd_q        <= 5'd0;
            f3_q        <= 3'd0;
            addr_q      <= 32'h0;
            pc4_q       <= 32'h0;
            rdata_q     <= 32'h0;
            ack_q       <= 1'b0;
            done_pend_q <= 1'b0;
            err_pend_q  <= 1'b0;
            wreg_q      <= 5'd0;
            wdata_q     <= 32'h0;
        end else begin
            if (accept) begin
                sel_q  <= sel_in;
                rd_q   <= rd_i;
                f3_q   <= funct3_i;
                addr_q <= alu_result_i;
                pc4_q  <= pc_plus4_i;
            end
            if (capture) begin
                rdata_q <= mem_rdata_i;
            end
            // Remembers an ack taken under freeze until the move to WRITE
            if (state_nxt != S_MEM_WAIT) begin
                ack_q <= 1'b0;
            end else if (capture) begin
                ack_q <= 1'b1;
            end
            // No-op and rejected requests finish from IDLE one cycle
            // later; a freeze holds the pending pulse.
            if (!freeze_i) begin
                done_pend_q <= accept && ((sel_in == WB_NONE) || ld_reject);
                err_pend_q  <= accept && ld_reject;
            end
            if (reg_write_o) begin
                wreg_q  <= rd_q;
                wdata_q <= wb_value;
            end
        end
    end

    assign mem_addr_o   = {addr_q[31:2], 2'b00};
    assign write_reg_o  = reg_write_o ? rd_q : wreg_q;
    assign write_data_o = reg_write_o ? wb_value : wdata_q;

endmodule
